// File: rtl/xid_pkg.sv
// Shared types and constants for the XID packet window feeding the byte-pattern matcher.
// Slot index is {core, thread}; a beat carries its own slot tag and per-beat scan enable.
package xid_pkg;

    localparam int XID_DATA_W = 64;
    localparam int XID_N_SLOT = 8;
    localparam int XID_SLOT_W = 3;

    typedef logic [XID_SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic [XID_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  core;
        logic [1:0]            thread;
        logic                  scan;
    } beat_t;

    function automatic slot_t slot_idx(input logic core, input logic [1:0] thread);
        return {core, thread};
    endfunction

endpackage

// File: rtl/xid_sat_cnt.sv
// Saturating event counter; sticks at all-ones.
// Latency: count visible the cycle after inc.
// Backpressure: none, counts every cycle inc is high.
module xid_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xid_pkt_window.sv
// Per-slot beat window for the XID matcher; reports one hit/no-hit result per packet.
// Latency: accept -> acc_valid 1 cycle, eop accept -> res_valid 2 cycles.
// Backpressure: in_ready follows cfg_enable only; result side never stalls.
module xid_pkt_window
    import xid_pkg::*;
#(
    parameter int DATA_W = XID_DATA_W,
    parameter int N_CORE = 2,
    parameter int N_THR  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic                     in_core,
    input  logic [1:0]               in_thread,
    input  logic                     in_scan,
    output logic [DATA_W-1:0]        acc_curr,
    output logic [DATA_W-1:0]        acc_prev,
    output logic                     acc_match_en,
    output logic                     acc_core,
    output logic [1:0]               acc_thread,
    output logic                     acc_valid,
    input  logic                     acc_match,
    output logic                     res_valid,
    output logic                     res_core,
    output logic [1:0]               res_thread,
    output logic                     res_hit,
    output logic [N_CORE*N_THR-1:0]  hit_flags,
    input  logic [N_CORE*N_THR-1:0]  hit_clr,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic                     err_orphan,
    output logic                     err_resop
);

    localparam int N_SLOT = N_CORE * N_THR;

    logic [DATA_W-1:0] prev_word [N_SLOT];
    logic [N_SLOT-1:0] in_pkt;
    logic [N_SLOT-1:0] pkt_hit;

    beat_t             in_beat;
    slot_t             in_slot;
    logic              accept;
    logic              orphan;
    logic              take;

    beat_t             acc_q;
    logic [DATA_W-1:0] acc_prev_q;
    logic              acc_vld_q;

    assign in_ready = cfg_enable;
    assign in_beat  = '{data: in_data, sop: in_sop, eop: in_eop,
                        core: in_core, thread: in_thread, scan: in_scan};
    assign in_slot  = slot_idx(in_core, in_thread);
    assign accept   = in_valid & cfg_enable;
    assign orphan   = accept & ~in_sop & ~in_pkt[in_slot];
    assign take     = accept & ~orphan;

    // Stage 1: slot context lookup/update and register toward the matcher.
    // prev_word is written on the accept edge, so a following beat of the
    // same slot already reads the new word without extra bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOT; i++) begin
                prev_word[i] <= '0;
            end
            in_pkt     <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            acc_vld_q  <= 1'b0;
            err_orphan <= 1'b0;
            err_resop  <= 1'b0;
        end else begin
            acc_vld_q  <= take;
            err_orphan <= orphan;
            err_resop  <= take & in_sop & in_pkt[in_slot];
            if (take) begin
                acc_q              <= in_beat;
                acc_prev_q         <= in_sop ? '0 : prev_word[in_slot];
                prev_word[in_slot] <= in_data;
                in_pkt[in_slot]    <= ~in_eop;
            end
        end
    end

    assign acc_curr     = acc_q.data;
    assign acc_prev     = acc_prev_q;
    assign acc_core     = acc_q.core;
    assign acc_thread   = acc_q.thread;
    assign acc_valid    = acc_vld_q;
    assign acc_match_en = acc_vld_q & acc_q.scan;

    // Stage 2: fold the matcher result into the packet and emit on eop.
    slot_t             acc_slot;
    logic              hit;
    logic              pkt_res;
    logic              done;
    logic [N_SLOT-1:0] hit_vec;

    assign acc_slot = slot_idx(acc_q.core, acc_q.thread);
    assign hit      = acc_match & acc_match_en;
    // An sop beat starts fresh, which also discards an abandoned packet's hit.
    assign pkt_res  = (~acc_q.sop & pkt_hit[acc_slot]) | hit;
    assign done     = acc_vld_q & acc_q.eop;

    always_comb begin
        hit_vec           = '0;
        hit_vec[acc_slot] = hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_hit    <= '0;
            res_valid  <= 1'b0;
            res_core   <= 1'b0;
            res_thread <= '0;
            res_hit    <= 1'b0;
            hit_flags  <= '0;
        end else begin
            res_valid <= done;
            hit_flags <= (hit_flags & ~hit_clr) | hit_vec;
            if (acc_vld_q) begin
                pkt_hit[acc_slot] <= acc_q.eop ? 1'b0 : pkt_res;
            end
            if (done) begin
                res_core   <= acc_q.core;
                res_thread <= acc_q.thread;
                res_hit    <= pkt_res;
            end
        end
    end

    xid_sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done),
        .cnt   (pkt_cnt)
    );

    xid_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done & pkt_res),
        .cnt   (hit_cnt)
    );

endmodule
